// File: rtl/trap_controller_if.sv
// -----------------------------------------------------------------------------
// trap_controller_if
// Groups the signals exchanged between the trap controller and the core around
// it: exception detector, decoder, debug logic, CSR file and PC unit.
//
// Signals
//   trapped, trap_status, mret, resume, pc, csr_read_data   core    -> controller
//   csr_read_address, csr_write_enable, csr_write_address,
//   csr_write_data, pc_stall, pc_redirect, trap_target,
//   debug_mode, trap_done                                    controller -> core
//
// Modports
//   master : the core side, which drives the trap/decode inputs
//   slave  : the trap controller itself
// -----------------------------------------------------------------------------
interface trap_controller_if;
    logic        trapped;
    logic [1:0]  trap_status;
    logic        mret;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] csr_read_data;

    logic [11:0] csr_read_address;
    logic        csr_write_enable;
    logic [11:0] csr_write_address;
    logic [31:0] csr_write_data;
    logic        pc_stall;
    logic        pc_redirect;
    logic [31:0] trap_target;
    logic        debug_mode;
    logic        trap_done;

    modport master (
        output trapped, trap_status, mret, resume, pc, csr_read_data,
        input  csr_read_address, csr_write_enable, csr_write_address,
               csr_write_data, pc_stall, pc_redirect, trap_target,
               debug_mode, trap_done
    );

    modport slave (
        input  trapped, trap_status, mret, resume, pc, csr_read_data,
        output csr_read_address, csr_write_enable, csr_write_address,
               csr_write_data, pc_stall, pc_redirect, trap_target,
               debug_mode, trap_done
    );
endinterface

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
// Machine-mode trap sequencer. On an ECALL or misaligned-jump trap it writes
// mepc and mcause, reads mtvec and redirects the PC there. On EBREAK it parks
// the core in a debug halt until resume, then redirects to pc+4. On MRET it
// reads mepc and redirects to it. The pipeline is stalled for the whole
// sequence, except on the cycle the redirect is taken.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : trap_controller_if.slave (trap inputs, CSR port, PC control)
// -----------------------------------------------------------------------------
module trap_controller (
    input  logic              clk,
    input  logic              reset,
    trap_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_MEPC    = 3'd1,
        ST_WR_MCAUSE  = 3'd2,
        ST_RD_MTVEC   = 3'd3,
        ST_DEBUG_HALT = 3'd4,
        ST_RD_MEPC    = 3'd5,
        ST_REDIRECT   = 3'd6
    } state_t;

    localparam logic [1:0]  CAUSE_NONE      = 2'b00;
    localparam logic [1:0]  CAUSE_EBREAK    = 2'b01;
    localparam logic [1:0]  CAUSE_ECALL     = 2'b10;
    localparam logic [1:0]  CAUSE_MISALIGN  = 2'b11;

    localparam logic [11:0] CSR_MEPC        = 12'h341;
    localparam logic [11:0] CSR_MCAUSE      = 12'h342;
    localparam logic [11:0] CSR_MTVEC       = 12'h305;

    localparam logic [31:0] MCAUSE_ECALL    = 32'd11;
    localparam logic [31:0] MCAUSE_MISALIGN = 32'd0;

    // Targets fetched from mtvec/mepc drop the two low bits (mtvec mode
    // field, or a stray unaligned mepc value).
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] mcause_code(input logic [1:0] cause);
        logic [31:0] code;
        case (cause)
            CAUSE_ECALL:    code = MCAUSE_ECALL;
            CAUSE_MISALIGN: code = MCAUSE_MISALIGN;
            default:        code = 32'd0;
        endcase
        return code;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [1:0]  cause_r;
    logic [31:0] target_r;

    logic        trap_valid_s;
    logic        trap_to_csr_s;
    logic        trap_to_debug_s;

    // Decode of the incoming trap; status 00 is not a trap at all.
    always_comb begin
        trap_valid_s    = bus.trapped && (bus.trap_status != CAUSE_NONE);
        trap_to_debug_s = bus.trapped && (bus.trap_status == CAUSE_EBREAK);
        trap_to_csr_s   = bus.trapped &&
                          ((bus.trap_status == CAUSE_ECALL) ||
                           (bus.trap_status == CAUSE_MISALIGN));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a valid trap in IDLE takes priority over MRET.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trap_to_csr_s) begin
                    state_next_s = ST_WR_MEPC;
                end else if (trap_to_debug_s) begin
                    state_next_s = ST_DEBUG_HALT;
                end else if (bus.mret) begin
                    state_next_s = ST_RD_MEPC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR_MEPC:   state_next_s = ST_WR_MCAUSE;
            ST_WR_MCAUSE: state_next_s = ST_RD_MTVEC;
            ST_RD_MTVEC:  state_next_s = ST_REDIRECT;
            ST_RD_MEPC:   state_next_s = ST_REDIRECT;
            ST_REDIRECT:  state_next_s = ST_IDLE;
            ST_DEBUG_HALT: begin
                if (bus.resume) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DEBUG_HALT;
                end
            end
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // Trap context: faulting pc and cause captured in IDLE, redirect target
    // captured from the CSR read port in the two read states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= 32'd0;
            cause_r  <= 2'b00;
            target_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trap_valid_s) begin
                        pc_r <= bus.pc;
                    end
                    if (trap_to_csr_s) begin
                        cause_r <= bus.trap_status;
                    end
                end
                ST_RD_MTVEC, ST_RD_MEPC: begin
                    target_r <= word_align(bus.csr_read_data);
                end
                default: begin
                    target_r <= target_r;
                end
            endcase
        end
    end

    // Output decode. pc_stall in IDLE looks at the live inputs so the
    // trapping instruction is held before the first state change; it is
    // forced low while reset is asserted so every output reads 0 then.
    always_comb begin
        bus.csr_read_address  = 12'd0;
        bus.csr_write_enable  = 1'b0;
        bus.csr_write_address = 12'd0;
        bus.csr_write_data    = 32'd0;
        bus.pc_stall          = 1'b0;
        bus.pc_redirect       = 1'b0;
        bus.trap_target       = 32'd0;
        bus.debug_mode        = 1'b0;
        bus.trap_done         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!reset && (trap_valid_s || bus.mret)) begin
                    bus.pc_stall = 1'b1;
                end else begin
                    bus.pc_stall = 1'b0;
                end
            end
            ST_WR_MEPC: begin
                bus.pc_stall          = 1'b1;
                bus.csr_write_enable  = 1'b1;
                bus.csr_write_address = CSR_MEPC;
                bus.csr_write_data    = pc_r;
            end
            ST_WR_MCAUSE: begin
                bus.pc_stall          = 1'b1;
                bus.csr_write_enable  = 1'b1;
                bus.csr_write_address = CSR_MCAUSE;
                bus.csr_write_data    = mcause_code(cause_r);
            end
            ST_RD_MTVEC: begin
                bus.pc_stall         = 1'b1;
                bus.csr_read_address = CSR_MTVEC;
            end
            ST_RD_MEPC: begin
                bus.pc_stall         = 1'b1;
                bus.csr_read_address = CSR_MEPC;
            end
            ST_REDIRECT: begin
                // Stall drops so the PC takes trap_target on this edge.
                bus.pc_redirect = 1'b1;
                bus.trap_done   = 1'b1;
                bus.trap_target = target_r;
            end
            ST_DEBUG_HALT: begin
                bus.debug_mode = 1'b1;
                if (bus.resume) begin
                    // pc + 4 wraps naturally in 32 bits.
                    bus.pc_redirect = 1'b1;
                    bus.trap_done   = 1'b1;
                    bus.trap_target = pc_r + 32'd4;
                    bus.pc_stall    = 1'b0;
                end else begin
                    bus.pc_stall    = 1'b1;
                end
            end
            default: begin
                bus.pc_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
// Self-checking bench for trap_controller. Each trap/MRET/debug transaction is
// expanded into the cycle-by-cycle output sequence the controller must show;
// a small CSR file model answers the read port and records writes.
// -----------------------------------------------------------------------------
module tb_trap_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    trap_controller_if bus_if ();

    trap_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // CSR file model
    logic [31:0] csr_mepc   = 32'd0;
    logic [31:0] csr_mcause = 32'd0;
    logic [31:0] csr_mtvec  = 32'd0;
    int          csr_write_count = 0;

    assign bus_if.csr_read_data =
        (bus_if.csr_read_address == 12'h341) ? csr_mepc   :
        (bus_if.csr_read_address == 12'h342) ? csr_mcause :
        (bus_if.csr_read_address == 12'h305) ? csr_mtvec  : 32'd0;

    // CSR file write port
    always @(posedge clk) begin
        if (bus_if.csr_write_enable) begin
            csr_write_count <= csr_write_count + 1;
            case (bus_if.csr_write_address)
                12'h341: csr_mepc   <= bus_if.csr_write_data;
                12'h342: csr_mcause <= bus_if.csr_write_data;
                default: ;
            endcase
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_mepc = 32'd0;
    logic [31:0] exp_mcause = 32'd0;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag, input logic stall,
                             input logic we, input logic [11:0] waddr,
                             input logic [31:0] wdata, input logic [11:0] raddr,
                             input logic redirect, input logic [31:0] target,
                             input logic debug, input logic done);
        check_value({tag, "/pc_stall"},    32'(bus_if.pc_stall), 32'(stall));
        check_value({tag, "/csr_we"},      32'(bus_if.csr_write_enable), 32'(we));
        check_value({tag, "/csr_waddr"},   32'(bus_if.csr_write_address), 32'(waddr));
        check_value({tag, "/csr_wdata"},   bus_if.csr_write_data, wdata);
        check_value({tag, "/csr_raddr"},   32'(bus_if.csr_read_address), 32'(raddr));
        check_value({tag, "/pc_redirect"}, 32'(bus_if.pc_redirect), 32'(redirect));
        check_value({tag, "/debug_mode"},  32'(bus_if.debug_mode), 32'(debug));
        check_value({tag, "/trap_done"},   32'(bus_if.trap_done), 32'(done));
        if (redirect) begin
            check_value({tag, "/trap_target"}, bus_if.trap_target, target);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic stall,
                                input logic we, input logic [11:0] waddr,
                                input logic [31:0] wdata, input logic [11:0] raddr,
                                input logic redirect, input logic [31:0] target,
                                input logic debug, input logic done);
        @(negedge clk);
        check_now(tag, stall, we, waddr, wdata, raddr, redirect, target, debug, done);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.trapped     = 1'b0;
        bus_if.trap_status = 2'b00;
        bus_if.mret        = 1'b0;
        bus_if.resume      = 1'b0;
        bus_if.pc          = $urandom;
    endtask

    // Random activity on inputs that the current state must ignore.
    task automatic noise(input bit allow_resume);
        bus_if.trapped     = 1'($urandom_range(1, 0));
        bus_if.trap_status = 2'($urandom_range(3, 0));
        bus_if.mret        = 1'($urandom_range(1, 0));
        bus_if.resume      = allow_resume ? 1'($urandom_range(1, 0)) : 1'b0;
        bus_if.pc          = $urandom;
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [1:0] status,
                           input logic with_mret);
        next_cycle();
        bus_if.trapped     = 1'b1;
        bus_if.trap_status = status;
        bus_if.pc          = pc;
        bus_if.mret        = with_mret;
        bus_if.resume      = 1'($urandom_range(1, 0));
        exp_mepc   = pc;
        exp_mcause = (status == 2'b10) ? 32'd11 : 32'd0;
        expect_cycle("trap_detect", 1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle(); noise(1'b1);
        expect_cycle("wr_mepc", 1'b1, 1'b1, 12'h341, exp_mepc, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle(); noise(1'b1);
        expect_cycle("wr_mcause", 1'b1, 1'b1, 12'h342, exp_mcause, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle(); noise(1'b1);
        expect_cycle("rd_mtvec", 1'b1, 1'b0, 12'h0, 32'h0, 12'h305, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle(); noise(1'b1);
        expect_cycle("trap_redirect", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b1,
                     {csr_mtvec[31:2], 2'b00}, 1'b0, 1'b1);
        next_cycle(); idle_inputs();
        expect_cycle("trap_after", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_value("mepc_written", csr_mepc, exp_mepc);
        check_value("mcause_written", csr_mcause, exp_mcause);
    endtask

    task automatic do_mret();
        next_cycle();
        bus_if.trapped     = 1'($urandom_range(1, 0));
        bus_if.trap_status = 2'b00;
        bus_if.mret        = 1'b1;
        expect_cycle("mret_detect", 1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle(); noise(1'b1);
        expect_cycle("rd_mepc", 1'b1, 1'b0, 12'h0, 32'h0, 12'h341, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle(); noise(1'b1);
        expect_cycle("mret_redirect", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b1,
                     {exp_mepc[31:2], 2'b00}, 1'b0, 1'b1);
        next_cycle(); idle_inputs();
        expect_cycle("mret_after", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_debug(input logic [31:0] pc, input int wait_n);
        int writes_before;
        next_cycle();
        bus_if.trapped     = 1'b1;
        bus_if.trap_status = 2'b01;
        bus_if.pc          = pc;
        bus_if.mret        = 1'($urandom_range(1, 0));
        expect_cycle("dbg_detect", 1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        writes_before = csr_write_count;
        for (int i = 0; i < wait_n; i++) begin
            next_cycle(); noise(1'b0);
            expect_cycle("dbg_halt", 1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        next_cycle(); noise(1'b0);
        bus_if.resume = 1'b1;
        expect_cycle("dbg_resume", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b1, pc + 32'd4, 1'b1, 1'b1);
        next_cycle(); idle_inputs();
        expect_cycle("dbg_after", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_value("dbg_no_csr_write", 32'(csr_write_count), 32'(writes_before));
    endtask

    task automatic do_no_trap();
        next_cycle();
        bus_if.trapped     = 1'b1;
        bus_if.trap_status = 2'b00;
        bus_if.mret        = 1'b0;
        expect_cycle("status00", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle(); idle_inputs();
        expect_cycle("status00_after", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset_abort(input logic [31:0] pc);
        logic [31:0] mcause_before;
        int          writes_before;
        next_cycle();
        bus_if.trapped     = 1'b1;
        bus_if.trap_status = 2'b10;
        bus_if.pc          = pc;
        bus_if.mret        = 1'b0;
        expect_cycle("abort_detect", 1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        exp_mepc = pc;
        next_cycle(); noise(1'b1);
        expect_cycle("abort_wr_mepc", 1'b1, 1'b1, 12'h341, pc, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        bus_if.trapped     = 1'b1;
        bus_if.trap_status = 2'b10;
        bus_if.mret        = 1'b1;
        mcause_before = csr_mcause;
        writes_before = csr_write_count;
        reset = 1'b1;
        #1;
        check_now("abort_in_reset", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        check_now("abort_reset_hold", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        expect_cycle("abort_after", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_value("abort_mcause_kept", csr_mcause, mcause_before);
        check_value("abort_no_write", 32'(csr_write_count), 32'(writes_before));
        check_value("abort_mepc", csr_mepc, exp_mepc);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        csr_mtvec = 32'h0000_2001;
        bus_if.trapped     = 1'b1;
        bus_if.trap_status = 2'b10;
        bus_if.mret        = 1'b1;
        bus_if.resume      = 1'b1;
        #2;
        check_now("reset", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_now("reset_hold", 1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        idle_inputs();

        do_trap(32'h0000_0100, 2'b10, 1'b0);
        do_trap(32'h0000_0040, 2'b11, 1'b0);
        do_debug(32'hFFFF_FFFC, 5);
        do_trap(32'h0000_0104, 2'b10, 1'b0);
        do_mret();
        do_trap(32'h0000_0500, 2'b10, 1'b1);
        do_no_trap();
        do_reset_abort(32'h0000_077C);
        do_trap(32'h0000_0200, 2'b11, 1'b0);

        for (int n = 0; n < 40; n++) begin
            csr_mtvec = $urandom;
            case ($urandom_range(4, 0))
                0: do_trap($urandom, 2'b10, 1'($urandom_range(1, 0)));
                1: do_trap($urandom, 2'b11, 1'($urandom_range(1, 0)));
                2: do_debug($urandom, $urandom_range(4, 0));
                3: do_mret();
                default: do_no_trap();
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
